// File: rtl/vga_out_timing.sv
// vga_out_timing: 1024x768@60 raster timing, pixel return path and registered VGA pins.
// Counts are issued upstream; pixels come back PIPE_DEPTH cycles later and are re-aligned with their syncs.
//
// Ports:
//   clk_in        pixel clock
//   rst_in        asynchronous active-high reset
//   pixel_in      returned pixel {R,G,B}, PIPE_DEPTH cycles after its coordinate
//   hcount_out    horizontal count 0..H_TOTAL-1
//   vcount_out    vertical count 0..V_TOTAL-1
//   active_out    coordinate is inside the visible area
//   new_frame_out single-cycle pulse on the last cycle of a frame
//   vga_r/g/b     registered colour, forced black in blanking
//   vga_hs/vs     registered syncs, active low
module vga_out_timing #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [11:0] pixel_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        active_out,
  output logic        new_frame_out,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } tap_t;

  localparam tap_t TAP_RST = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

  // Compare at full integer width so no total is ever truncated.
  int   h_i;
  int   v_i;
  logic h_last;
  logic v_last;
  tap_t cur;
  tap_t sr [PIPE_DEPTH];

  assign h_i    = int'(hcount_out);
  assign v_i    = int'(vcount_out);
  assign h_last = (h_i == H_TOTAL - 1);
  assign v_last = (v_i == V_TOTAL - 1);

  assign active_out    = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
  assign new_frame_out = h_last && v_last;

  assign cur.act = active_out;
  assign cur.hs  = !((h_i >= HS_START) && (h_i < HS_END));
  assign cur.vs  = !((v_i >= VS_START) && (v_i < VS_END));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcount_out <= '0;
      vcount_out <= '0;
    end else if (h_last) begin
      hcount_out <= '0;
      vcount_out <= v_last ? '0 : vcount_out + 10'd1;
    end else begin
      hcount_out <= hcount_out + 11'd1;
    end
  end

  // Delay line matching the upstream render latency.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sr[i] <= TAP_RST;
      end
    end else begin
      sr[0] <= cur;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  // Output register: pixel_in now belongs to the coordinate in the last tap.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      {vga_r, vga_g, vga_b} <= sr[PIPE_DEPTH-1].act ? pixel_in : 12'h000;
      vga_hs <= sr[PIPE_DEPTH-1].hs;
      vga_vs <= sr[PIPE_DEPTH-1].vs;
    end
  end

endmodule

// File: tb/tb_vga_out_timing.sv
// tb_vga_out_timing: directed + random-pixel bench for vga_out_timing.
// Two instances (PIPE_DEPTH 1 and 8) on a reduced raster, checked against a cycle-index model.
module tb_vga_out_timing;

  localparam int HA = 20, HF = 3, HSY = 5, HB = 4;
  localparam int VA = 6, VF = 1, VSY = 2, VB = 3;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pixel = 12'h000;

  logic [10:0] a_hc, b_hc;
  logic [9:0]  a_vc, b_vc;
  logic        a_act, b_act, a_nf, b_nf;
  logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  logic        a_hs, a_vs, b_hs, b_vs;

  int compared = 0;
  int mismatched = 0;
  int n = 0;
  bit fff_mode = 0;
  logic [11:0] hist [0:8191];

  always #5 clk = ~clk;

  vga_out_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .PIPE_DEPTH(1)
  ) u_p1 (
    .clk_in(clk), .rst_in(rst), .pixel_in(pixel),
    .hcount_out(a_hc), .vcount_out(a_vc),
    .active_out(a_act), .new_frame_out(a_nf),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
    .vga_hs(a_hs), .vga_vs(a_vs)
  );

  vga_out_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .PIPE_DEPTH(8)
  ) u_p8 (
    .clk_in(clk), .rst_in(rst), .pixel_in(pixel),
    .hcount_out(b_hc), .vcount_out(b_vc),
    .active_out(b_act), .new_frame_out(b_nf),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
    .vga_hs(b_hs), .vga_vs(b_vs)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  // Expected state from the cycle index since reset release.
  task automatic check_dut(string nm, int p,
                           logic [10:0] hc, logic [9:0] vc,
                           logic act, logic nf,
                           logic [3:0] r, logic [3:0] g, logic [3:0] b,
                           logic hs, logic vs);
    int h, v, m, hm, vm;
    bit e_act, e_hs, e_vs;
    logic [11:0] e_rgb;
    h = n % HT;
    v = (n / HT) % VT;
    chk({nm, ".hcount"}, 32'(hc), 32'(h));
    chk({nm, ".vcount"}, 32'(vc), 32'(v));
    chk({nm, ".active"}, 32'(act), 32'(h < HA && v < VA));
    chk({nm, ".new_frame"}, 32'(nf), 32'(h == HT-1 && v == VT-1));
    if (n < p + 1) begin
      e_rgb = 12'h000; e_hs = 1; e_vs = 1;
    end else begin
      m  = n - p - 1;
      hm = m % HT;
      vm = (m / HT) % VT;
      e_act = (hm < HA) && (vm < VA);
      e_hs  = !(hm >= HA+HF && hm < HA+HF+HSY);
      e_vs  = !(vm >= VA+VF && vm < VA+VF+VSY);
      e_rgb = e_act ? hist[n-1] : 12'h000;
    end
    chk({nm, ".rgb"}, 32'({r, g, b}), 32'(e_rgb));
    chk({nm, ".hs"}, 32'(hs), 32'(e_hs));
    chk({nm, ".vs"}, 32'(vs), 32'(e_vs));
  endtask

  task automatic check_rst(string nm, logic [10:0] hc, logic [9:0] vc,
                           logic [3:0] r, logic [3:0] g, logic [3:0] b,
                           logic hs, logic vs);
    chk({nm, ".rst_hcount"}, 32'(hc), 32'd0);
    chk({nm, ".rst_vcount"}, 32'(vc), 32'd0);
    chk({nm, ".rst_rgb"}, 32'({r, g, b}), 32'h000);
    chk({nm, ".rst_hs"}, 32'(hs), 32'd1);
    chk({nm, ".rst_vs"}, 32'(vs), 32'd1);
  endtask

  task automatic check_both();
    check_dut("p1", 1, a_hc, a_vc, a_act, a_nf, a_r, a_g, a_b, a_hs, a_vs);
    check_dut("p8", 8, b_hc, b_vc, b_act, b_nf, b_r, b_g, b_b, b_hs, b_vs);
  endtask

  task automatic rst_both();
    check_rst("p1", a_hc, a_vc, a_r, a_g, a_b, a_hs, a_vs);
    check_rst("p8", b_hc, b_vc, b_r, b_g, b_b, b_hs, b_vs);
  endtask

  task automatic drive();
    pixel = fff_mode ? 12'hFFF : 12'($urandom);
    hist[n] = pixel;
  endtask

  // Called one time unit after a rising edge with rst just released.
  task automatic release_rst();
    rst = 1'b0;
    n = 0;
    check_both();
    drive();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    check_both();
    drive();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_both();
    release_rst();

    // Random pixels through two full frames.
    repeat (2 * FT + 20) step();

    // Constant white: must only show in the visible area.
    fff_mode = 1;
    repeat (FT + 10) step();
    fff_mode = 0;

    // Advance to mid-line of line 4 then reset between edges.
    while (!((n % HT) == HT/2 && ((n / HT) % VT) == 4)) step();
    #2;
    rst = 1'b1;
    #1;
    rst_both();
    repeat (3) begin
      @(posedge clk);
      #1;
      rst_both();
    end
    release_rst();

    // Next frame pulse lands exactly FT-1 cycles after release.
    repeat (FT + 30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
